// File: rtl/prio_enc_arb.sv
// Registered priority encoder / arbiter: picks one active request bit each load
// and holds the index plus one-hot grant in a valid/ready output register.
module prio_enc_arb #(
  parameter int N    = 8,
  parameter int MODE = 0,
  localparam int W   = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_grant,
  output logic         out_multi,
  output logic [W-1:0] rr_ptr
);

  logic [W-1:0] sel_idx;
  logic [W-1:0] next_ptr;
  logic         found;
  logic         multi;
  logic         load;
  int           pos;

  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    pos     = 0;
    if (MODE == 0) begin
      // Ascending scan, last hit wins: highest set index.
      for (int i = 0; i < N; i++) begin
        if (req[i]) sel_idx = W'(i);
      end
    end else begin
      // Scan starts at rr_ptr and wraps at N, so no index >= N is ever visited.
      for (int k = 0; k < N; k++) begin
        pos = int'(rr_ptr) + k;
        if (pos >= N) pos = pos - N;
        if (!found && req[pos]) begin
          found   = 1'b1;
          sel_idx = W'(pos);
        end
      end
    end
  end

  assign multi    = |(req & (req - N'(1)));
  assign next_ptr = (sel_idx == W'(N-1)) ? '0 : sel_idx + W'(1);
  assign load     = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_grant <= '0;
      out_multi <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (|req) begin
        out_valid <= 1'b1;
        out_idx   <= sel_idx;
        out_grant <= N'(1) << sel_idx;
        out_multi <= multi;
        if (MODE == 1) rr_ptr <= next_ptr;
      end else begin
        out_valid <= 1'b0;
        out_grant <= '0;
        out_multi <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed bench: fixed priority (N=8), round-robin (N=8) and round-robin (N=5).
module tb_prio_enc_arb;

  logic clk;
  logic rst_n;

  logic [7:0] req_a;
  logic       rdy_a;
  logic       vld_a;
  logic [2:0] idx_a;
  logic [7:0] gnt_a;
  logic       mul_a;
  logic [2:0] rr_a;

  logic [7:0] req_b;
  logic       rdy_b;
  logic       vld_b;
  logic [2:0] idx_b;
  logic [7:0] gnt_b;
  logic       mul_b;
  logic [2:0] rr_b;

  logic [4:0] req_c;
  logic       rdy_c;
  logic       vld_c;
  logic [2:0] idx_c;
  logic [4:0] gnt_c;
  logic       mul_c;
  logic [2:0] rr_c;

  int errors = 0;
  int checks = 0;

  prio_enc_arb #(.N(8), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .out_ready(rdy_a),
    .out_valid(vld_a), .out_idx(idx_a), .out_grant(gnt_a),
    .out_multi(mul_a), .rr_ptr(rr_a)
  );

  prio_enc_arb #(.N(8), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .out_ready(rdy_b),
    .out_valid(vld_b), .out_idx(idx_b), .out_grant(gnt_b),
    .out_multi(mul_b), .rr_ptr(rr_b)
  );

  prio_enc_arb #(.N(5), .MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .out_ready(rdy_c),
    .out_valid(vld_c), .out_idx(idx_c), .out_grant(gnt_c),
    .out_multi(mul_c), .rr_ptr(rr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0; rdy_a = 1'b1;
    req_b = '0; rdy_b = 1'b1;
    req_c = '0; rdy_c = 1'b1;
    #2;
    check("rst_valid", 64'(vld_a), 64'd0);
    check("rst_idx",   64'(idx_a), 64'd0);
    check("rst_grant", 64'(gnt_a), 64'd0);
    check("rst_multi", 64'(mul_a), 64'd0);
    check("rst_rr",    64'(rr_b),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Legacy one-hot equivalence
    req_a = 8'h00;
    step();
    check("zero_valid", 64'(vld_a), 64'd0);
    for (int i = 0; i < 8; i++) begin
      req_a = 8'(1 << i);
      step();
      check("oh_valid", 64'(vld_a), 64'd1);
      check("oh_idx",   64'(idx_a), 64'(i));
      check("oh_grant", 64'(gnt_a), 64'(1 << i));
      check("oh_multi", 64'(mul_a), 64'd0);
    end
    check("fixed_rr_zero", 64'(rr_a), 64'd0);

    // Fixed priority, several requests
    req_a = 8'h5A;
    step();
    check("fp_idx",   64'(idx_a), 64'd6);
    check("fp_grant", 64'(gnt_a), 64'h40);
    check("fp_multi", 64'(mul_a), 64'd1);

    // Backpressure hold
    req_a = 8'h04;
    step();
    check("bp_first_idx", 64'(idx_a), 64'd2);
    rdy_a = 1'b0;
    req_a = 8'h80;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", 64'(vld_a), 64'd1);
      check("bp_hold_idx",   64'(idx_a), 64'd2);
      check("bp_hold_grant", 64'(gnt_a), 64'h04);
    end
    rdy_a = 1'b1;
    step();
    check("bp_release_idx",   64'(idx_a), 64'd7);
    check("bp_release_multi", 64'(mul_a), 64'd0);
    req_a = 8'h00;
    step();
    check("empty_valid", 64'(vld_a), 64'd0);
    check("empty_grant", 64'(gnt_a), 64'd0);
    check("empty_multi", 64'(mul_a), 64'd0);
    check("empty_idx_hold", 64'(idx_a), 64'd7);

    // Round-robin rotation and wrap, N=8
    req_b = 8'h91;
    step(); check("rr8_idx", 64'(idx_b), 64'd0); check("rr8_ptr", 64'(rr_b), 64'd1);
    check("rr8_multi", 64'(mul_b), 64'd1);
    step(); check("rr8_idx", 64'(idx_b), 64'd4); check("rr8_ptr", 64'(rr_b), 64'd5);
    step(); check("rr8_idx", 64'(idx_b), 64'd7); check("rr8_ptr", 64'(rr_b), 64'd0);
    check("rr8_grant", 64'(gnt_b), 64'h80);
    step(); check("rr8_idx", 64'(idx_b), 64'd0); check("rr8_ptr", 64'(rr_b), 64'd1);
    step(); check("rr8_idx", 64'(idx_b), 64'd4); check("rr8_ptr", 64'(rr_b), 64'd5);
    step(); check("rr8_idx", 64'(idx_b), 64'd7); check("rr8_ptr", 64'(rr_b), 64'd0);
    step(); check("rr8_idx", 64'(idx_b), 64'd0); check("rr8_ptr", 64'(rr_b), 64'd1);
    rdy_b = 1'b0;
    step(); check("rr8_stall_ptr", 64'(rr_b), 64'd1); check("rr8_stall_idx", 64'(idx_b), 64'd0);
    step(); check("rr8_stall_ptr", 64'(rr_b), 64'd1);

    // Non-power-of-two wrap, N=5
    req_c = 5'h11;
    for (int i = 0; i < 3; i++) begin
      step(); check("rr5_idx", 64'(idx_c), 64'd0); check("rr5_ptr", 64'(rr_c), 64'd1);
      step(); check("rr5_idx", 64'(idx_c), 64'd4); check("rr5_ptr", 64'(rr_c), 64'd0);
      check("rr5_grant", 64'(gnt_c), 64'h10);
    end

    // Reset mid-stall, asserted between clock edges
    req_a = 8'h10;
    step();
    check("ms_idx", 64'(idx_a), 64'd4);
    rdy_a = 1'b0;
    step();
    check("ms_stall_valid", 64'(vld_a), 64'd1);
    req_a = 8'h22;
    #2;
    rst_n = 1'b0;
    #1;
    check("ms_rst_valid", 64'(vld_a), 64'd0);
    check("ms_rst_grant", 64'(gnt_a), 64'd0);
    check("ms_rst_rr",    64'(rr_b),  64'd0);
    check("ms_rst_bvalid", 64'(vld_b), 64'd0);
    #3;
    rst_n = 1'b1;
    step();
    check("ms_reload_valid", 64'(vld_a), 64'd1);
    check("ms_reload_idx",   64'(idx_a), 64'd5);
    check("ms_reload_grant", 64'(gnt_a), 64'h20);
    check("ms_reload_multi", 64'(mul_a), 64'd1);
    check("ms_reload_bidx",  64'(idx_b), 64'd0);
    check("ms_reload_brr",   64'(rr_b),  64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prio_enc_arb.md
Name: prio_enc_arb

Overview:
- Parametrised, registered successor to the 8-to-3 combinational encoder.
- Samples an N-bit request vector and selects one active bit. Selection is fixed-priority or round-robin.
- Presents the selected index and its one-hot grant through a valid/ready output register.
- Sits between request sources (interrupt lines, channel requests) and a single consumer that services one index per accepted transfer.

Parameters:
- N, 8, number of request inputs; legal range 2..64, need not be a power of two.
- MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.
- W, $clog2(N), index width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  level request vector; bit i set means requester i is active.
- out_ready  in  1  consumer accepts the current output this cycle.
- out_valid  out  1  out_idx, out_grant and out_multi hold a valid selection.
- out_idx  out  W  binary index of the selected request.
- out_grant  out  N  one-hot of out_idx; all zero when out_valid = 0.
- out_multi  out  1  more than one req bit was set when the current selection was captured.
- rr_ptr  out  W  current round-robin search start (debug; constant 0 when MODE = 0).

Behaviour:
- Reset (rst_n low, asynchronous, any time): out_valid=0, out_idx=0, out_grant=0, out_multi=0, rr_ptr=0. A transfer in flight is dropped, not completed. Release is synchronous to clk.
- Load condition: load = (!out_valid || out_ready), evaluated each rising edge.
- If load and |req:
  - register the selected index into out_idx;
  - set out_grant = 1<<idx;
  - set out_multi = (popcount(req) > 1);
  - set out_valid = 1.
- If load and req == 0: out_valid=0, out_grant=0, out_multi=0. out_idx holds its last value (don't-care).
- If !load (out_valid=1, out_ready=0): all outputs hold stable. req changes during the stall are ignored, with no sampling and no pointer movement.
- Latency: request sampled at edge k appears on out_* after edge k (1 cycle).
- Throughput: with out_ready held at 1, one new selection every cycle. Accept and reload happen on the same edge with no bubble.
- MODE=0 selection: highest set index in req. This matches the legacy encoder for one-hot inputs.
- MODE=1 selection:
  - search starts at rr_ptr and ascends, wrapping from N-1 to 0; the first set bit wins.
  - on every load with |req: rr_ptr <= (idx == N-1) ? 0 : idx+1.
  - rr_ptr does not change on loads with req == 0, nor while stalled.
- Wrap for non-power-of-two N: rr_ptr never takes a value >= N. Index values >= N are never produced.
- Fairness (MODE=1): a continuously asserted request is granted within N loads.
- Handshake rule: out_valid never drops without acceptance. Once out_valid=1, it stays 1 with identical out_idx and out_grant until out_ready=1 is seen at a rising edge, or reset.
- out_ready while out_valid=0 has no effect beyond enabling load.
- No combinational path from req or out_ready to any output; all outputs are registers.

Test Plan:
- Reset and legacy one-hot equivalence:
  - stimulus: N=8, MODE=0, out_ready=1; drive req=0x00, then 0x01, 0x02, … 0x80, one per cycle;
  - response: out_valid=0 for 0x00; then out_idx 0..7 one cycle after each input, out_grant equal to the input, out_multi=0.
- Fixed priority with multiple requests:
  - stimulus: MODE=0, req=0x5A;
  - response: out_idx=6, out_grant=0x40, out_multi=1.
- Backpressure hold:
  - stimulus: MODE=0, req=0x04 with out_ready=0 for 5 cycles, req changed to 0x80 during the stall, then out_ready=1;
  - response: out_idx stays 2 with out_valid=1 for all 5 cycles; the edge after acceptance gives out_idx=7.
- Round-robin rotation and wrap:
  - stimulus: N=8, MODE=1, req=0x91 held, out_ready=1;
  - response: out_idx sequence 0,4,7,0,4,7; rr_ptr sequence 1,5,0,1,…
- Non-power-of-two wrap:
  - stimulus: N=5, MODE=1, req=0x11 held;
  - response: out_idx alternates 0,4; rr_ptr never exceeds 4.
- Reset mid-stall:
  - stimulus: out_valid=1, out_ready=0, then rst_n pulsed low between clock edges;
  - response: out_valid=0, out_grant=0, rr_ptr=0 immediately, without waiting for a clock edge; after release, the next load re-selects from the current req.
